// File: rtl/sync_fifo_gen2.sv
// sync_fifo_gen2: parametrised single-clock FIFO with registered-read or
// first-word-fall-through output, occupancy/peak monitor, sticky error
// flags and synchronous flush.
module sync_fifo_gen2 #(
   parameter int unsigned DATA_WIDTH             = 8,
   parameter int unsigned INDEX_WIDTH            = 2,
   parameter int unsigned ALMOST_FULL_THRESHOLD  = 2,
   parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1,
   parameter int unsigned FWFT                   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   input  logic                   flush,
   input  logic                   clr_err,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [INDEX_WIDTH:0]   count,
   output logic [INDEX_WIDTH:0]   peak,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned    DEPTH = 1 << INDEX_WIDTH;
   localparam int unsigned    PW    = INDEX_WIDTH + 1;
   localparam logic [PW-1:0]  DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0]  AF_C    = PW'(ALMOST_FULL_THRESHOLD);
   localparam logic [PW-1:0]  AE_C    = PW'(ALMOST_EMPTY_THRESHOLD);
   localparam logic [PW-1:0]  ONE     = PW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt, count_nxt;
   logic                  wr_acc, rd_acc, ovf_evt, unf_evt;

   // Pointers wrap modulo 2*DEPTH, so their difference is the occupancy 0..DEPTH.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // Acceptance, error events and next pointer values from pre-edge state.
   always_comb begin
      wr_acc     = wr_en && !full && !flush;
      rd_acc     = rd_en && !empty && !flush;
      ovf_evt    = wr_en && full && !flush;
      unf_evt    = rd_en && empty && !flush;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (wr_acc) wr_ptr_nxt = wr_ptr + ONE;
         if (rd_acc) rd_ptr_nxt = rd_ptr + ONE;
      end
      count_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[PW-2:0]] <= wr_data;
   end

   // Peak monitor: clr_err restarts it from the new occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           peak <= '0;
      else if (clr_err || count_nxt > peak) peak <= count_nxt;
   end

   // Sticky error flags; a new event in the clearing cycle wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (unf_evt)      underflow <= 1'b1;
         else if (clr_err) underflow <= 1'b0;
      end
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         // Registered read: data loads on an accepted pop, valid pulses one cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) rd_data <= mem[rd_ptr[PW-2:0]];
            end
         end
      end else begin : g_fwft
         // Head of queue is always presented; valid whenever non-empty.
         assign rd_data  = mem[rd_ptr[PW-2:0]];
         assign rd_valid = !empty;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Self-checking bench for sync_fifo_gen2: a registered-read and an FWFT
// instance share stimulus; a queue scoreboard holds the expected contents.
module tb_sync_fifo_gen2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
   logic [7:0] wr_data = '0;

   logic [7:0] rd_data0, rd_data1;
   logic       rd_valid0, rd_valid1;
   logic       full0, empty0, af0, ae0, ovf0, unf0;
   logic       full1, empty1, af1, ae1, ovf1, unf1;
   logic [2:0] count0, peak0, count1, peak1;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   // scoreboard / reference state
   logic [7:0] sb[$];
   int unsigned m_peak;
   bit         m_ovf, m_unf, m_rv;
   logic [7:0] m_rd;

   always #5 clk = ~clk;

   sync_fifo_gen2 #(.DATA_WIDTH(8), .INDEX_WIDTH(2), .ALMOST_FULL_THRESHOLD(2),
                    .ALMOST_EMPTY_THRESHOLD(1), .FWFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .flush(flush), .clr_err(clr_err), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(count0), .peak(peak0), .overflow(ovf0), .underflow(unf0));

   sync_fifo_gen2 #(.DATA_WIDTH(8), .INDEX_WIDTH(2), .ALMOST_FULL_THRESHOLD(2),
                    .ALMOST_EMPTY_THRESHOLD(1), .FWFT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .flush(flush), .clr_err(clr_err), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(count1), .peak(peak1), .overflow(ovf1), .underflow(unf1));

   task automatic model_reset();
      sb.delete();
      m_peak = 0; m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
   endtask

   // Drive one cycle of stimulus, advance the reference at the edge, settle.
   task automatic step(input bit w, input logic [7:0] d, input bit r,
                       input bit f, input bit c);
      bit was_full, was_empty;
      wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
      @(posedge clk);
      was_full  = (sb.size() == 4);
      was_empty = (sb.size() == 0);
      m_rv = 0;
      if (f) sb.delete();
      else begin
         if (r && !was_empty) begin m_rd = sb.pop_front(); m_rv = 1; end
         if (w && !was_full) sb.push_back(d);
      end
      if (w && was_full && !f)       m_ovf = 1;
      else if (c)                    m_ovf = 0;
      if (r && was_empty && !f)      m_unf = 1;
      else if (c)                    m_unf = 0;
      if (c || sb.size() > m_peak)   m_peak = sb.size();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12;
      n_chk++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty0); end
      n_chk++; if (ae0 !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got %b want 1", ae0); end
      n_chk++; if (full0 !== 1'b0 || af0 !== 1'b0) begin n_fail++; $display("FAIL reset_full_af got %b%b want 00", full0, af0); end
      n_chk++; if (count0 !== 3'd0 || peak0 !== 3'd0) begin n_fail++; $display("FAIL reset_count_peak got %0d/%0d want 0/0", count0, peak0); end
      n_chk++; if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h00) begin n_fail++; $display("FAIL reset_rd got %b/%h want 0/00", rd_valid0, rd_data0); end
      n_chk++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL reset_errors got %b%b want 00", ovf0, unf0); end
      n_chk++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_fwft_valid got %b want 0", rd_valid1); end
      rst_n = 1'b1;
      step(0, 8'h00, 0, 0, 0);
      n_chk++; if (count0 !== 3'd0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL reset_release got %0d/%b want 0/1", count0, empty0); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         step(1, 8'(8'h11 * (i + 1)), 0, 0, 0);
         n_chk++; if (count0 !== 3'(sb.size())) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count0, sb.size()); end
         n_chk++; if (af0 !== (sb.size() >= 2)) begin n_fail++; $display("FAIL fill_almost_full got %b want %b", af0, sb.size() >= 2); end
         n_chk++; if (full0 !== (sb.size() == 4)) begin n_fail++; $display("FAIL fill_full got %b want %b", full0, sb.size() == 4); end
         n_chk++; if (empty0 !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", empty0); end
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 8'h00, 1, 0, 0);
         n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== m_rd) begin n_fail++; $display("FAIL drain_data got %b/%h want 1/%h", rd_valid0, rd_data0, m_rd); end
      end
      step(0, 8'h00, 0, 0, 0);
      n_chk++; if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h44) begin n_fail++; $display("FAIL drain_pulse_hold got %b/%h want 0/44", rd_valid0, rd_data0); end
      n_chk++; if (empty0 !== 1'b1 || count0 !== 3'd0) begin n_fail++; $display("FAIL drain_empty got %b/%0d want 1/0", empty0, count0); end
      n_chk++; if (peak0 !== 3'd4) begin n_fail++; $display("FAIL drain_peak got %0d want 4", peak0); end
   endtask

   task automatic test_ovf_unf();
      for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
      step(1, 8'h55, 1, 0, 0);
      n_chk++; if (ovf0 !== 1'b1 || ovf0 !== m_ovf) begin n_fail++; $display("FAIL overflow_flag got %b want 1", ovf0); end
      n_chk++; if (count0 !== 3'd3) begin n_fail++; $display("FAIL overflow_count got %0d want 3", count0); end
      n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 8'hA0) begin n_fail++; $display("FAIL overflow_pop got %b/%h want 1/a0", rd_valid0, rd_data0); end
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 1, 0, 0);
         n_chk++; if (rd_data0 !== m_rd) begin n_fail++; $display("FAIL overflow_drain got %h want %h", rd_data0, m_rd); end
      end
      n_chk++; if (rd_data0 === 8'h55) begin n_fail++; $display("FAIL overflow_dropped got %h want not 55", rd_data0); end
      step(0, 8'h00, 1, 0, 0);
      n_chk++; if (unf0 !== 1'b1 || rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL underflow got %b/%b want 1/0", unf0, rd_valid0); end
      step(1, 8'h61, 0, 0, 0);
      step(1, 8'h62, 0, 0, 0);
      step(0, 8'h00, 0, 0, 1);
      n_chk++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL clr_err_flags got %b%b want 00", ovf0, unf0); end
      n_chk++; if (peak0 !== 3'd2) begin n_fail++; $display("FAIL clr_err_peak got %0d want 2", peak0); end
      step(1, 8'h63, 0, 0, 1);
      n_chk++; if (peak0 !== 3'd3 || peak0 !== 3'(m_peak)) begin n_fail++; $display("FAIL clr_err_with_write_peak got %0d want 3", peak0); end
      step(0, 8'h00, 1, 0, 0);
      n_chk++; if (rd_data0 !== 8'h61 || count0 !== 3'd2) begin n_fail++; $display("FAIL pre_wrap got %h/%0d want 61/2", rd_data0, count0); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(8'h80 + i), 1, 0, 0);
         n_chk++; if (count0 !== 3'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", count0); end
         n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== m_rd) begin n_fail++; $display("FAIL wrap_data got %b/%h want 1/%h", rd_valid0, rd_data0, m_rd); end
         n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== sb[0]) begin n_fail++; $display("FAIL wrap_fwft_head got %b/%h want 1/%h", rd_valid1, rd_data1, sb[0]); end
      end
      n_chk++; if (ovf0 !== m_ovf || unf0 !== m_unf) begin n_fail++; $display("FAIL wrap_errors got %b%b want %b%b", ovf0, unf0, m_ovf, m_unf); end
   endtask

   task automatic test_fwft();
      step(0, 8'h00, 0, 1, 0);
      n_chk++; if (empty1 !== 1'b1 || rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL fwft_empty got %b/%b want 1/0", empty1, rd_valid1); end
      step(1, 8'hA5, 0, 0, 0);
      n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== 8'hA5) begin n_fail++; $display("FAIL fwft_fallthrough got %b/%h want 1/a5", rd_valid1, rd_data1); end
      n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL regread_no_pop got %b want 0", rd_valid0); end
      step(0, 8'h00, 0, 0, 0);
      n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== 8'hA5) begin n_fail++; $display("FAIL fwft_hold got %b/%h want 1/a5", rd_valid1, rd_data1); end
      step(0, 8'h00, 1, 0, 0);
      n_chk++; if (rd_valid1 !== 1'b0 || count1 !== 3'd0) begin n_fail++; $display("FAIL fwft_pop got %b/%0d want 0/0", rd_valid1, count1); end
   endtask

   task automatic test_flush();
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 8'hC0) begin n_fail++; $display("FAIL flush_pre_read got %b/%h want 1/c0", rd_valid0, rd_data0); end
      step(1, 8'h99, 1, 1, 0);
      n_chk++; if (count0 !== 3'd0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL flush_count got %0d/%b want 0/1", count0, empty0); end
      n_chk++; if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b%b want 00", rd_valid0, rd_valid1); end
      n_chk++; if (peak0 !== 3'd3) begin n_fail++; $display("FAIL flush_peak got %0d want 3", peak0); end
      n_chk++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL flush_errors got %b%b want 00", ovf0, unf0); end
      step(1, 8'h12, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      n_chk++; if (rd_data0 !== 8'h12 || rd_data0 !== m_rd) begin n_fail++; $display("FAIL flush_no_store got %h want 12", rd_data0); end
   endtask

   task automatic test_async_reset();
      step(1, 8'h31, 0, 0, 0);
      step(1, 8'h32, 1, 0, 0);
      step(1, 8'h33, 0, 0, 0);
      n_chk++; if (count0 !== 3'd2 || rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL prereset_state got %0d/%b want 2/0", count0, rd_valid0); end
      step(0, 8'h00, 1, 0, 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++; if (count0 !== 3'd0 || empty0 !== 1'b1 || ae0 !== 1'b1) begin n_fail++; $display("FAIL async_reset_count got %0d/%b/%b want 0/1/1", count0, empty0, ae0); end
      n_chk++; if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h00 || rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_rd got %b/%h/%b want 0/00/0", rd_valid0, rd_data0, rd_valid1); end
      n_chk++; if (peak0 !== 3'd0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_misc got %0d/%b%b want 0/00", peak0, ovf0, unf0); end
      #3 rst_n = 1'b1;
      step(1, 8'h44, 0, 0, 0);
      n_chk++; if (count0 !== 3'd1 || rd_data1 !== 8'h44) begin n_fail++; $display("FAIL post_reset_write got %0d/%h want 1/44", count0, rd_data1); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill_drain();
      test_ovf_unf();
      test_back_to_back();
      test_fwft();
      test_flush();
      test_async_reset();
      step(0, 8'h00, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
